lamp_conflict_monitor: RTL
==========================

# lamp_conflict_monitor

Independent safety monitor that observes the four lamp vectors driven by the intersection sequencer. It reads the lamps the same way a field conflict monitor reads load-switch outputs. It flags three kinds of unsafe or inconsistent lamp state: conflicting right-of-way, illegal lamp combinations, and missing or short clearance intervals. On a fault it latches the fault, reports a code and the offending signal, and asserts `force_attention`, which feeds back to the sequencer's `attention` input to put the intersection into flashing operation.

## Interface
Parameters:
- `PERMIT` — 6'b000000 — compatible-pair mask: bit0 = (0,1), bit1 = (0,2), bit2 = (0,3), bit3 = (1,2), bit4 = (1,3), bit5 = (2,3); 1 = the pair may both show non-red.
- `CONFLICT_CYCLES` — 2 — consecutive samples a conflict must persist before fault (1..255).
- `INVALID_CYCLES` — 4 — consecutive samples an illegal lamp combination must persist before fault (1..255).
- `MIN_YELLOW` — 3 — minimum yellow-only samples before red (1..255).
- `STARTUP_CYCLES` — 8 — samples ignored after reset release (0..255).

Ports:
- `clk` — in — 1 — sole clock; all state changes on the rising edge.
- `rst` — in — 1 — asynchronous, active-low reset.
- `ltfs` — in — [3:0][0:2] — lamp vector per signal; `[i][0]` = red, `[i][1]` = yellow, `[i][2]` = green.
- `attention` — in — 1 — sequencer is in flashing mode.
- `clear` — in — 1 — single-cycle request to clear a latched fault.
- `fault` — out — 1 — latched fault.
- `fault_code` — out — 2 — 0 = none, 1 = conflict, 2 = invalid lamp, 3 = clearance violation.
- `fault_signal` — out — 2 — offending signal index; for a conflict, the lower index of the pair.
- `force_attention` — out — 1 — equals `fault`.

## Operation
- Each signal is classified every cycle:
  - R = red only.
  - Y = yellow only.
  - G = green only.
  - D = dark.
  - X = more than one lamp lit.
  - Non-red means Y or G.
- State machine, 3 states:
  - STARTUP: entered on reset. The startup counter runs 0..`STARTUP_CYCLES`. Moves to MONITOR when the counter equals `STARTUP_CYCLES`; with 0 it moves to MONITOR on the first edge. All checks are suppressed.
  - MONITOR: checks are active. Moves to FAULT on the edge where any check fires.
  - FAULT: outputs are frozen. Moves back to MONITOR on a `clear` sample only if no check condition is present in that same sample; otherwise `clear` is ignored.
- Conflict check: any pair (i,j) with both signals non-red and its `PERMIT` bit 0. A single shared 8-bit counter increments while any conflict is present and clears to 0 when none is. It fires when the counter reaches `CONFLICT_CYCLES`.
- Invalid check, one counter per signal:
  - Condition when `attention` = 0: class D or X.
  - Condition when `attention` = 1: class G or X; dark and yellow are legal.
  - It fires at `INVALID_CYCLES`.
- Clearance check, one 8-bit saturating yellow counter per signal:
  - The counter increments while the signal is Y and loads 0 when the signal is not Y.
  - It fires on a R sample whose previous sample was Y with count < `MIN_YELLOW`.
  - It also fires on a direct G→R transition.
  - Suppressed while `attention` = 1, and on the first sample after `attention` falls.
- While `attention` = 1, the conflict check and conflict counter are held at 0.
- Priority when several checks fire in the same cycle: conflict > invalid > clearance. Within a class, the lowest signal index wins; for conflicts, the lowest pair bit wins.
- All persistence and yellow counters saturate at 255 and never wrap.

## Timing
- Reset values: state = STARTUP, `fault` = 0, `fault_code` = 0, `fault_signal` = 0, `force_attention` = 0, all counters 0, previous-class registers = R.
- Latency: a condition present on N consecutive edges (N = its threshold) makes `fault` high immediately after the Nth edge. A clearance violation is flagged immediately after the edge that samples R.
- `clear` accepted on edge k → `fault`, `fault_code` and `fault_signal` are 0 after edge k, and the counters restart from 0 at edge k+1.
- `clear` while in MONITOR or STARTUP has no effect.
- Reset asserted mid-fault: all outputs drop asynchronously, and the block restarts in STARTUP.

## Test plan
- **Startup suppression:** all signals G for 6 cycles after reset, defaults → `fault` stays 0. Sustaining G into cycle 9 onward → `fault` = 1, code 1, signal 0, two edges after MONITOR is entered.
- **Conflict persistence:** signals 1 and 3 both G for 1 cycle → no fault. Both G for 2 cycles → code 1, `fault_signal` = 1. Repeat with `PERMIT` = 6'b010000 → no fault.
- **Invalid lamp:** signal 2 = 3'b110 for 3 cycles then R → no fault. For 4 cycles → code 2, signal 2. During `attention` = 1, signal 2 dark for 20 cycles → no fault.
- **Clearance:** signal 0 G→Y(2 cycles)→R → code 3, signal 0. G→Y(3 cycles)→R → no fault. G→R → code 3.
- **Priority and clear:** conflict on pair (0,1) and invalid on signal 3 in the same cycle → code 1. `clear` while the conflict persists → fault held. Conflict removed, then `clear` → `fault` = 0 on the next cycle.
- **Async reset in FAULT:** drop `rst` between edges → all outputs 0 before the next edge.

Source files
------------

// File: rtl/lamp_conflict_monitor.sv
// lamp_conflict_monitor: independent watchdog on the sequencer lamp outputs.
// Latches a fault on conflicting right-of-way, illegal lamp combinations or
// short/missing clearance, and drives force_attention back to the sequencer.
module lamp_conflict_monitor #(
  parameter logic [5:0]  PERMIT          = 6'b000000,
  parameter int unsigned CONFLICT_CYCLES = 2,
  parameter int unsigned INVALID_CYCLES  = 4,
  parameter int unsigned MIN_YELLOW      = 3,
  parameter int unsigned STARTUP_CYCLES  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0][0:2] ltfs,
  input  logic            attention,
  input  logic            clear,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [1:0]      fault_signal,
  output logic            force_attention
);

  localparam logic [7:0] CONF_TH  = 8'(CONFLICT_CYCLES);
  localparam logic [7:0] INV_TH   = 8'(INVALID_CYCLES);
  localparam logic [7:0] MIN_Y    = 8'(MIN_YELLOW);
  localparam logic [7:0] START_TH = 8'(STARTUP_CYCLES);

  // Lower signal index of each compatible-pair bit (0,1),(0,2),(0,3),(1,2),(1,3),(2,3)
  localparam logic [5:0][1:0] PAIR_LO = {2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};

  typedef enum logic [1:0] {ST_STARTUP, ST_MONITOR, ST_FAULT} state_e;
  typedef enum logic [2:0] {CL_R, CL_Y, CL_G, CL_D, CL_X} lamp_cls_e;

  state_e          state_q, state_d;
  logic [7:0]      st_cnt_q, st_cnt_d;
  logic [7:0]      conf_cnt_q, conf_cnt_d;
  logic [3:0][7:0] inv_cnt_q, inv_cnt_d;
  logic [3:0][7:0] ycnt_q, ycnt_d;
  logic [3:0][2:0] prev_q, prev_d;
  logic            att_q, att_d;
  logic            fault_q, fault_d;
  logic [1:0]      code_q, code_d;
  logic [1:0]      sig_q, sig_d;

  logic [3:0][2:0] cls;
  logic [3:0]      nonred, inv_cond, inv_fire, clr_fire;
  logic [5:0]      pair_conf;
  logic            conf_any, conf_fire, any_fire, any_cond;
  logic [7:0]      conf_inc;
  logic [3:0][7:0] inv_inc;
  logic [1:0]      fire_code, fire_sig;

  // Classify each signal's lamp vector as R/Y/G/dark/multiple
  always_comb begin
    cls = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      case (ltfs[i])
        3'b100:  cls[i] = CL_R;
        3'b010:  cls[i] = CL_Y;
        3'b001:  cls[i] = CL_G;
        3'b000:  cls[i] = CL_D;
        default: cls[i] = CL_X;
      endcase
    end
  end

  // Evaluate the three checks and pick the highest-priority firing one
  always_comb begin
    logic found;
    found     = 1'b0;
    fire_code = '0;
    fire_sig  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      nonred[i] = (cls[i] == CL_Y) || (cls[i] == CL_G);
    end
    pair_conf[0] = nonred[0] & nonred[1] & ~PERMIT[0];
    pair_conf[1] = nonred[0] & nonred[2] & ~PERMIT[1];
    pair_conf[2] = nonred[0] & nonred[3] & ~PERMIT[2];
    pair_conf[3] = nonred[1] & nonred[2] & ~PERMIT[3];
    pair_conf[4] = nonred[1] & nonred[3] & ~PERMIT[4];
    pair_conf[5] = nonred[2] & nonred[3] & ~PERMIT[5];
    if (attention) pair_conf = '0;
    conf_any  = |pair_conf;
    conf_inc  = (conf_cnt_q == 8'hFF) ? 8'hFF : conf_cnt_q + 8'd1;
    conf_fire = conf_any && (conf_inc >= CONF_TH);
    for (int unsigned i = 0; i < 4; i++) begin
      inv_cond[i] = attention ? ((cls[i] == CL_G) || (cls[i] == CL_X))
                              : ((cls[i] == CL_D) || (cls[i] == CL_X));
      inv_inc[i]  = (inv_cnt_q[i] == 8'hFF) ? 8'hFF : inv_cnt_q[i] + 8'd1;
      inv_fire[i] = inv_cond[i] && (inv_inc[i] >= INV_TH);
      clr_fire[i] = !attention && !att_q && (cls[i] == CL_R) &&
                    (((prev_q[i] == CL_Y) && (ycnt_q[i] < MIN_Y)) || (prev_q[i] == CL_G));
      ycnt_d[i]   = (cls[i] != CL_Y) ? 8'd0 :
                    (ycnt_q[i] == 8'hFF) ? 8'hFF : ycnt_q[i] + 8'd1;
      prev_d[i]   = cls[i];
    end
    att_d    = attention;
    any_fire = conf_fire || (|inv_fire) || (|clr_fire);
    any_cond = conf_any || (|inv_cond) || (|clr_fire);
    if (conf_fire) begin
      fire_code = 2'd1;
      for (int unsigned b = 0; b < 6; b++) begin
        if (!found && pair_conf[b]) begin
          found    = 1'b1;
          fire_sig = PAIR_LO[b];
        end
      end
    end else if (|inv_fire) begin
      fire_code = 2'd2;
      for (int unsigned i = 0; i < 4; i++) begin
        if (!found && inv_fire[i]) begin
          found    = 1'b1;
          fire_sig = 2'(i);
        end
      end
    end else if (|clr_fire) begin
      fire_code = 2'd3;
      for (int unsigned i = 0; i < 4; i++) begin
        if (!found && clr_fire[i]) begin
          found    = 1'b1;
          fire_sig = 2'(i);
        end
      end
    end
  end

  // Next-state logic: persistence counters only run in MONITOR and restart from 0 otherwise
  always_comb begin
    state_d    = state_q;
    st_cnt_d   = st_cnt_q;
    conf_cnt_d = '0;
    inv_cnt_d  = '0;
    fault_d    = fault_q;
    code_d     = code_q;
    sig_d      = sig_q;
    case (state_q)
      ST_STARTUP: begin
        if (st_cnt_q == START_TH) state_d = ST_MONITOR;
        else                      st_cnt_d = st_cnt_q + 8'd1;
      end
      ST_MONITOR: begin
        if (any_fire) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = fire_code;
          sig_d   = fire_sig;
        end else begin
          conf_cnt_d = conf_any ? conf_inc : 8'd0;
          for (int unsigned i = 0; i < 4; i++) begin
            inv_cnt_d[i] = inv_cond[i] ? inv_inc[i] : 8'd0;
          end
        end
      end
      ST_FAULT: begin
        if (clear && !any_cond) begin
          state_d = ST_MONITOR;
          fault_d = 1'b0;
          code_d  = '0;
          sig_d   = '0;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_STARTUP;
      st_cnt_q   <= '0;
      conf_cnt_q <= '0;
      inv_cnt_q  <= '0;
      ycnt_q     <= '0;
      prev_q     <= {CL_R, CL_R, CL_R, CL_R};
      att_q      <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= '0;
      sig_q      <= '0;
    end else begin
      state_q    <= state_d;
      st_cnt_q   <= st_cnt_d;
      conf_cnt_q <= conf_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      ycnt_q     <= ycnt_d;
      prev_q     <= prev_d;
      att_q      <= att_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
      sig_q      <= sig_d;
    end
  end

  assign fault           = fault_q;
  assign fault_code      = code_q;
  assign fault_signal    = sig_q;
  assign force_attention = fault_q;

endmodule
